// File: rtl/avalon_pio_ctrl.sv
// Avalon-MM parallel I/O controller: output register with atomic set/clear,
// timed pulse inversion, synchronised inputs with edge capture and interrupt.
module avalon_pio_ctrl #(
    parameter int unsigned            DATA_WIDTH   = 8,
    parameter logic [DATA_WIDTH-1:0]  RESET_VALUE  = '0,
    parameter int unsigned            EDGE_TYPE    = 0,
    parameter int unsigned            SYNC_STAGES  = 2,
    parameter int unsigned            PULSE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  irq
);

    localparam int unsigned CNT_W = 16;

    localparam logic [2:0] ADDR_OUT_DATA  = 3'd0;
    localparam logic [2:0] ADDR_IN_DATA   = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK  = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP  = 3'd3;
    localparam logic [2:0] ADDR_OUTSET    = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR  = 3'd5;
    localparam logic [2:0] ADDR_PULSE     = 3'd6;
    localparam logic [2:0] ADDR_STATUS    = 3'd7;

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  unused_wdata;

    logic [DATA_WIDTH-1:0] sync_ff [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] sync_q;
    logic [DATA_WIDTH-1:0] prev_q;
    logic [DATA_WIDTH-1:0] edge_det;

    logic [DATA_WIDTH-1:0] out_data;
    logic [DATA_WIDTH-1:0] irq_mask;
    logic [DATA_WIDTH-1:0] edge_cap;
    logic [DATA_WIDTH-1:0] edge_cap_nxt;
    logic [DATA_WIDTH-1:0] pulse_mask;
    logic [CNT_W-1:0]      cnt;
    logic                  pulse_active;
    logic                  pulse_load;

    assign wr_en        = chipselect && !write_n;
    assign wdata        = writedata[DATA_WIDTH-1:0];
    assign unused_wdata = ^writedata;

    // Input synchroniser chain plus one-cycle history for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_ff[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_ff[0] <= in_port;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_ff[i] <= sync_ff[i-1];
            end
            prev_q <= sync_q;
        end
    end

    assign sync_q = sync_ff[SYNC_STAGES-1];

    always_comb begin
        edge_det = '0;
        case (EDGE_TYPE)
            0:       edge_det = sync_q & ~prev_q;
            1:       edge_det = ~sync_q & prev_q;
            default: edge_det = sync_q ^ prev_q;
        endcase
    end

    // W1C clear first, then OR in new edges so a coincident edge survives
    always_comb begin
        edge_cap_nxt = edge_cap;
        if (wr_en && (address == ADDR_EDGE_CAP)) begin
            edge_cap_nxt = edge_cap & ~wdata;
        end
        edge_cap_nxt = edge_cap_nxt | edge_det;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cap <= '0;
        end else begin
            edge_cap <= edge_cap_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask <= '0;
        end else if (wr_en && (address == ADDR_IRQ_MASK)) begin
            irq_mask <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data <= RESET_VALUE;
        end else if (wr_en) begin
            case (address)
                ADDR_OUT_DATA: out_data <= wdata;
                ADDR_OUTSET:   out_data <= out_data | wdata;
                ADDR_OUTCLEAR: out_data <= out_data & ~wdata;
                default:       out_data <= out_data;
            endcase
        end
    end

    // Pulse engine: a nonzero load merges the mask and restarts the countdown
    assign pulse_active = |pulse_mask;
    assign pulse_load   = wr_en && (address == ADDR_PULSE) && (wdata != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pulse_mask <= '0;
            cnt        <= '0;
        end else if (pulse_load) begin
            pulse_mask <= pulse_mask | wdata;
            cnt        <= CNT_W'(PULSE_CYCLES - 1);
        end else if (pulse_active) begin
            if (cnt == '0) begin
                pulse_mask <= '0;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_OUT_DATA: readdata[DATA_WIDTH-1:0] = out_data;
            ADDR_IN_DATA:  readdata[DATA_WIDTH-1:0] = sync_q;
            ADDR_IRQ_MASK: readdata[DATA_WIDTH-1:0] = irq_mask;
            ADDR_EDGE_CAP: readdata[DATA_WIDTH-1:0] = edge_cap;
            ADDR_PULSE:    readdata[DATA_WIDTH-1:0] = pulse_mask;
            ADDR_STATUS:   readdata = {cnt, 15'd0, pulse_active};
            default:       readdata = '0;
        endcase
    end

    assign out_port = out_data ^ pulse_mask;
    assign irq      = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_avalon_pio_ctrl.sv
// Scoreboard bench for avalon_pio_ctrl: rising-edge and any-edge instances
// share one bus and are checked against a cycle-indexed reference model.
`timescale 1ns/1ps
module tb_avalon_pio_ctrl;

    localparam int unsigned DW   = 8;
    localparam logic [7:0]  RV   = 8'hA5;
    localparam int unsigned SYNC = 2;
    localparam int unsigned PCYC = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [7:0]  in_port = '0;
    logic [31:0] readdata_r, readdata_a;
    logic [7:0]  out_port_r, out_port_a;
    logic        irq_r, irq_a;

    always #5 clk = ~clk;

    avalon_pio_ctrl #(.DATA_WIDTH(DW), .RESET_VALUE(RV), .EDGE_TYPE(0),
                      .SYNC_STAGES(SYNC), .PULSE_CYCLES(PCYC)) u_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata_r),
        .in_port(in_port), .out_port(out_port_r), .irq(irq_r));

    avalon_pio_ctrl #(.DATA_WIDTH(DW), .RESET_VALUE(RV), .EDGE_TYPE(2),
                      .SYNC_STAGES(SYNC), .PULSE_CYCLES(PCYC)) u_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata_a),
        .in_port(in_port), .out_port(out_port_a), .irq(irq_a));

    typedef struct {
        string       tag;
        logic [31:0] rd_r;
        logic [31:0] rd_a;
        logic [7:0]  outp;
        logic        irq_r;
        logic        irq_a;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    // Reference model: architectural state plus a per-edge record of inputs
    logic [7:0] m_out, m_imask, m_ecap_r, m_ecap_a, m_pmask;
    int         m_pend;
    int         m_cur;
    logic [7:0] m_samp[$];

    task automatic model_reset();
        m_out = RV; m_imask = '0; m_ecap_r = '0; m_ecap_a = '0; m_pmask = '0;
        m_pend = 0; m_cur = 0;
        m_samp.delete();
        m_samp.push_back(8'h00);
    endtask

    // IN_DATA after edge m equals the input sampled at edge m-SYNC+1
    function automatic logic [7:0] sync_at(int m);
        int j = m - int'(SYNC) + 1;
        return (j >= 1) ? m_samp[j] : 8'h00;
    endfunction

    task automatic model_tick();
        logic [7:0] s_now, s_prev, wd, clr;
        logic       wr;
        s_now  = sync_at(m_cur);
        s_prev = sync_at(m_cur - 1);
        wd     = writedata[7:0];
        wr     = chipselect && !write_n;
        clr    = (wr && address == 3'd3) ? wd : 8'h00;
        m_ecap_r = (m_ecap_r & ~clr) | (s_now & ~s_prev);
        m_ecap_a = (m_ecap_a & ~clr) | (s_now ^ s_prev);
        if (wr) begin
            case (address)
                3'd0: m_out = wd;
                3'd2: m_imask = wd;
                3'd4: m_out = m_out | wd;
                3'd5: m_out = m_out & ~wd;
                default: ;
            endcase
        end
        m_cur++;
        if (wr && address == 3'd6 && wd != 8'h00) begin
            m_pmask = m_pmask | wd;
            m_pend  = m_cur + int'(PCYC);
        end else if (m_pmask != 8'h00 && m_cur >= m_pend) begin
            m_pmask = 8'h00;
        end
        m_samp.push_back(in_port);
    endtask

    function automatic logic [31:0] model_read(logic [2:0] a, bit any_edge);
        case (a)
            3'd0: return {24'd0, m_out};
            3'd1: return {24'd0, sync_at(m_cur)};
            3'd2: return {24'd0, m_imask};
            3'd3: return {24'd0, any_edge ? m_ecap_a : m_ecap_r};
            3'd6: return {24'd0, m_pmask};
            3'd7: return (m_pmask != 8'h00) ? {16'(m_pend - 1 - m_cur), 15'd0, 1'b1} : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic push_exp(string tag);
        exp_t e;
        e.tag   = tag;
        e.rd_r  = model_read(address, 1'b0);
        e.rd_a  = model_read(address, 1'b1);
        e.outp  = m_out ^ m_pmask;
        e.irq_r = |(m_ecap_r & m_imask);
        e.irq_a = |(m_ecap_a & m_imask);
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        if (reset_n) model_tick();
        #1;
    endtask

    task automatic cyc(string tag, logic [2:0] a, logic cs, logic wn, logic [31:0] d);
        address = a; chipselect = cs; write_n = wn; writedata = d;
        push_exp(tag);
        step();
    endtask

    task automatic wr(string tag, logic [2:0] a, logic [31:0] d);
        cyc(tag, a, 1'b1, 1'b0, d);
    endtask

    task automatic rd(string tag, logic [2:0] a);
        cyc(tag, a, 1'b1, 1'b1, $urandom);
    endtask

    // Reset is asserted mid-cycle so its asynchronous effect is observed
    task automatic do_reset(string tag);
        reset_n = 1'b0;
        model_reset();
        address = 3'($urandom_range(0, 7)); chipselect = 1'b0; write_n = 1'b1;
        push_exp(tag);
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic cmp(string tag, string field, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got %h expected %h (t=%0t)", tag, field, act, exp, $time);
        end
    endtask

    // Monitor: everything queued during a cycle is compared at the falling edge
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            cmp(e.tag, "readdata_rise", readdata_r, e.rd_r);
            cmp(e.tag, "readdata_any", readdata_a, e.rd_a);
            cmp(e.tag, "out_port_rise", 32'(out_port_r), 32'(e.outp));
            cmp(e.tag, "out_port_any", 32'(out_port_a), 32'(e.outp));
            cmp(e.tag, "irq_rise", 32'(irq_r), 32'(e.irq_r));
            cmp(e.tag, "irq_any", 32'(irq_a), 32'(e.irq_a));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  a;
        logic [31:0] d;
        int          r;

        model_reset();
        step();
        step();
        reset_n = 1'b1;

        // Reset values and full-word write to OUT_DATA
        rd("rst_out", 3'd0);
        rd("rst_mask", 3'd2);
        rd("rst_ecap", 3'd3);
        wr("wr_out", 3'd0, 32'hFFFF_FF3C);
        rd("out_3c", 3'd0);

        // Atomic set and clear
        wr("outset", 3'd4, 32'h81);
        rd("after_set", 3'd4);
        wr("outclear", 3'd5, 32'h0C);
        rd("after_clr", 3'd5);
        rd("out_b1", 3'd0);

        // Rising edge on bit2, interrupt, W1C, falling edge
        wr("imask", 3'd2, 32'h04);
        in_port = 8'h04;
        for (int i = 0; i < 4; i++) rd("rise_lat", 3'd3);
        rd("in_data", 3'd1);
        wr("w1c", 3'd3, 32'h04);
        rd("post_w1c", 3'd3);
        in_port = 8'h00;
        for (int i = 0; i < 4; i++) rd("fall_lat", 3'd3);
        wr("w1c_all", 3'd3, 32'hFF);

        // Edge detected in the same cycle as a W1C of that bit
        wr("imask1", 3'd2, 32'h01);
        in_port = 8'h01;
        rd("race_n", 3'd3);
        rd("race_n1", 3'd3);
        wr("race_w1c", 3'd3, 32'h01);
        rd("race_chk", 3'd3);
        rd("race_chk2", 3'd3);

        // Single pulse, then an overlapping reload
        wr("out_zero", 3'd0, 32'h00);
        wr("pulse10", 3'd6, 32'h10);
        for (int i = 0; i < 5; i++) rd("pulse_cnt", 3'd7);
        wr("pulse10b", 3'd6, 32'h10);
        rd("pulse_ov", 3'd7);
        wr("pulse01", 3'd6, 32'h01);
        for (int i = 0; i < 6; i++) rd("pulse_ext", 3'd7);
        wr("pulse_zero", 3'd6, 32'h00);
        rd("pulse_zero_chk", 3'd6);
        wr("set_mid", 3'd6, 32'h80);
        wr("set_during", 3'd4, 32'h81);
        rd("mix", 3'd6);

        // Reset during an active pulse
        wr("pulse_ff", 3'd6, 32'hFF);
        rd("pulse_ff_chk", 3'd6);
        do_reset("rst_pulse");
        rd("post_rst_stat", 3'd7);
        rd("post_rst_out", 3'd0);

        // Randomised traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) in_port = 8'($urandom);
            r = int'($urandom_range(0, 99));
            a = 3'($urandom_range(0, 7));
            d = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
            if (r < 1) do_reset("rnd_rst");
            else if (r < 45) wr("rnd_wr", a, d);
            else if (r < 85) rd("rnd_rd", a);
            else cyc("rnd_idle", a, 1'b0, 1'($urandom_range(0, 1)), d);
        end

        chipselect = 1'b0;
        step();
        step();
        cmp("scoreboard", "pending", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
